// File: rtl/obi_wb_master_bridge.sv
// rtl/obi_wb_master_bridge.sv - single-outstanding OBI data port to Wishbone classic master bridge

module obi_wb_master_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  wb_clk_i,
   input  logic                  rst_i,
   // OBI slave side (core LSU)
   input  logic                  obi_req_i,
   output logic                  obi_gnt_o,
   input  logic [ADDR_WIDTH-1:0] obi_addr_i,
   input  logic                  obi_we_i,
   input  logic [3:0]            obi_be_i,
   input  logic [31:0]           obi_wdata_i,
   output logic                  obi_rvalid_o,
   output logic [31:0]           obi_rdata_o,
   output logic                  obi_err_o,
   // Wishbone classic master side
   output logic [ADDR_WIDTH-1:0] wb_addr_o,
   output logic [31:0]           wb_wdata_o,
   output logic                  wb_we_o,
   output logic                  wb_stb_o,
   output logic                  wb_cyc_o,
   input  logic                  wb_ack_i,
   input  logic [31:0]           wb_rdata_i
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD      = 3'd1;
   localparam logic [2:0] S_WR      = 3'd2;
   localparam logic [2:0] S_RMW_RD  = 3'd3;
   localparam logic [2:0] S_RMW_GAP = 3'd4;
   localparam logic [2:0] S_RMW_WR  = 3'd5;
   localparam logic [2:0] S_RESP    = 3'd6;

   // The counter only has to reach TIMEOUT_CYCLES-1; the final waiting cycle is detected by compare.
   localparam int unsigned       CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [2:0]            state_q;
   logic [ADDR_WIDTH-1:0] wb_addr_q;
   logic [3:0]            be_q;
   logic [31:0]           wdata_q;
   logic [31:0]           wb_wdata_q;
   logic [31:0]           rdata_q;
   logic                  err_q;
   logic [CNT_W-1:0]      cnt_q;

   logic                  bus_active;
   logic                  timeout_hit;
   logic [31:0]           merged;
   logic                  unused_addr_lsb;

   // Byte lanes are word-aligned on the Wishbone side; the OBI byte offset is carried by be.
   assign unused_addr_lsb = ^obi_addr_i[1:0];

   assign bus_active = (state_q == S_RD) || (state_q == S_WR) ||
                       (state_q == S_RMW_RD) || (state_q == S_RMW_WR);

   // An ack in the last allowed cycle takes priority over the timeout.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && bus_active && !wb_ack_i && (cnt_q == CNT_LAST);

   // Merge the read-back word with the enabled write bytes for the RMW write phase.
   always_comb begin
      merged = wb_rdata_i;
      for (int i = 0; i < 4; i++) begin
         if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   // Main transaction FSM with per-phase timeout and response capture.
   always_ff @(posedge wb_clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         wb_addr_q  <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         wb_wdata_q <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (obi_req_i) begin
                  wb_addr_q  <= {obi_addr_i[ADDR_WIDTH-1:2], 2'b00};
                  be_q       <= obi_be_i;
                  wdata_q    <= obi_wdata_i;
                  wb_wdata_q <= obi_wdata_i;
                  rdata_q    <= '0;
                  err_q      <= 1'b0;
                  cnt_q      <= '0;
                  if (!obi_we_i)              state_q <= S_RD;
                  else if (obi_be_i == 4'hF)  state_q <= S_WR;
                  else if (obi_be_i == 4'h0)  state_q <= S_RESP;
                  else                        state_q <= S_RMW_RD;
               end
            end
            S_RD, S_WR, S_RMW_RD, S_RMW_WR: begin
               if (wb_ack_i) begin
                  case (state_q)
                     S_RD: begin
                        rdata_q <= wb_rdata_i;
                        state_q <= S_RESP;
                     end
                     S_RMW_RD: begin
                        wb_wdata_q <= merged;
                        state_q    <= S_RMW_GAP;
                     end
                     default: state_q <= S_RESP;
                  endcase
               end else if (timeout_hit) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RMW_GAP: begin
               // One idle bus cycle lets the downstream controller return to idle before the write.
               cnt_q   <= '0;
               state_q <= S_RMW_WR;
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign obi_gnt_o    = obi_req_i && (state_q == S_IDLE);
   assign obi_rvalid_o = (state_q == S_RESP);
   assign obi_rdata_o  = rdata_q;
   assign obi_err_o    = err_q;

   assign wb_cyc_o   = bus_active;
   assign wb_stb_o   = bus_active;
   assign wb_we_o    = (state_q == S_WR) || (state_q == S_RMW_WR);
   assign wb_addr_o  = wb_addr_q;
   assign wb_wdata_o = wb_wdata_q;

endmodule

// File: tb/tb_obi_wb_master_bridge.sv
// tb/tb_obi_wb_master_bridge.sv - scoreboard bench for obi_wb_master_bridge

module tb_obi_wb_master_bridge;

   localparam int          T    = 8;
   localparam logic [31:0] BASE = 32'h0003_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        obi_req;
   logic        obi_gnt;
   logic [31:0] obi_addr;
   logic        obi_we;
   logic [3:0]  obi_be;
   logic [31:0] obi_wdata;
   logic        obi_rvalid;
   logic [31:0] obi_rdata;
   logic        obi_err;
   logic [31:0] wb_addr;
   logic [31:0] wb_wdata;
   logic        wb_we;
   logic        wb_stb;
   logic        wb_cyc;
   logic        wb_ack;
   logic [31:0] wb_rdata;

   obi_wb_master_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
      .wb_clk_i     (clk),
      .rst_i        (rst),
      .obi_req_i    (obi_req),
      .obi_gnt_o    (obi_gnt),
      .obi_addr_i   (obi_addr),
      .obi_we_i     (obi_we),
      .obi_be_i     (obi_be),
      .obi_wdata_i  (obi_wdata),
      .obi_rvalid_o (obi_rvalid),
      .obi_rdata_o  (obi_rdata),
      .obi_err_o    (obi_err),
      .wb_addr_o    (wb_addr),
      .wb_wdata_o   (wb_wdata),
      .wb_we_o      (wb_we),
      .wb_stb_o     (wb_stb),
      .wb_cyc_o     (wb_cyc),
      .wb_ack_i     (wb_ack),
      .wb_rdata_i   (wb_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          lat;
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
   } phase_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          g;
   } resp_t;

   phase_t      phase_q[$];
   resp_t       exp_q[$];
   logic [31:0] slv_mem [16];
   logic [31:0] ref_mem [16];
   int          checks = 0;
   int          errors = 0;
   int          cyc_cnt = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gnt"},    32'(obi_gnt),    32'd0);
      chk({tag, "_rvalid"}, 32'(obi_rvalid), 32'd0);
      chk({tag, "_rdata"},  obi_rdata,       32'd0);
      chk({tag, "_err"},    32'(obi_err),    32'd0);
      chk({tag, "_cyc"},    32'(wb_cyc),     32'd0);
      chk({tag, "_stb"},    32'(wb_stb),     32'd0);
      chk({tag, "_we"},     32'(wb_we),      32'd0);
      chk({tag, "_addr"},   wb_addr,         32'd0);
      chk({tag, "_wdata"},  wb_wdata,        32'd0);
   endtask

   // Wishbone slave: each bus phase takes the latency the stimulus queued for it; random stray acks when idle
   initial begin
      int     s_cnt;
      bit     acked_prev;
      phase_t cur;
      s_cnt      = 0;
      acked_prev = 1'b0;
      cur        = '{1, 32'd0, 1'b0, 32'd0};
      wb_ack     = 1'b0;
      wb_rdata   = 32'd0;
      forever begin
         @(negedge clk);
         if (acked_prev) chk("cyc_low_after_ack", 32'(wb_cyc), 32'd0);
         acked_prev = 1'b0;
         if (rst) begin
            s_cnt  = 0;
            wb_ack = 1'b0;
         end else if (wb_cyc && wb_stb) begin
            if (s_cnt == 0) begin
               if (phase_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_wb_phase: got addr %h we %0d expected no bus phase", wb_addr, wb_we);
                  cur = '{1, wb_addr, wb_we, wb_wdata};
               end else begin
                  cur = phase_q.pop_front();
                  chk("wb_addr", wb_addr, {cur.addr[31:2], 2'b00});
                  chk("wb_we", 32'(wb_we), 32'(cur.we));
                  if (cur.we) chk("wb_wdata", wb_wdata, cur.data);
               end
            end
            s_cnt++;
            if (s_cnt == cur.lat) begin
               wb_ack     = 1'b1;
               acked_prev = 1'b1;
               if (wb_we) slv_mem[wb_addr[5:2]] = wb_wdata;
               else       wb_rdata = slv_mem[wb_addr[5:2]];
            end else begin
               wb_ack   = 1'b0;
               wb_rdata = $urandom;
            end
         end else begin
            s_cnt    = 0;
            wb_ack   = ($urandom_range(0, 3) == 0);
            wb_rdata = $urandom;
         end
      end
   end

   // Response monitor: every rvalid pops one expected response and checks data, error and latency
   initial begin
      resp_t e;
      forever begin
         @(negedge clk);
         if (obi_rvalid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rvalid: got rdata %h err %0d expected no response", obi_rdata, obi_err);
            end else begin
               e = exp_q.pop_front();
               chk("rdata", obi_rdata, e.rdata);
               chk("err", 32'(obi_err), 32'(e.err));
               chk("resp_latency", cyc_cnt - e.g, e.lat);
            end
         end
      end
   end

   // Issue one OBI request; on grant the reference model queues bus phases and the expected response.
   // Called at posedge+1; returns at posedge+1 after the granting edge.
   task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, input int l1, input int l2, input bit track);
      resp_t       e;
      logic [3:0]  idx;
      logic [31:0] m;
      int          n;
      obi_req   = 1'b1;
      obi_addr  = addr;
      obi_we    = we;
      obi_be    = be;
      obi_wdata = wdata;
      n = 0;
      @(negedge clk);
      while (!obi_gnt && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!obi_gnt) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout: got no grant expected grant within 100 cycles");
         @(posedge clk);
         #1 obi_req = 1'b0;
         return;
      end
      idx     = addr[5:2];
      e.g     = cyc_cnt;
      e.rdata = 32'd0;
      e.err   = 1'b0;
      e.lat   = 1;
      if (!we) begin
         phase_q.push_back('{l1, addr, 1'b0, 32'd0});
         if (l1 > T) begin e.err = 1'b1; e.lat = T + 1; end
         else begin e.rdata = ref_mem[idx]; e.lat = l1 + 1; end
      end else if (be == 4'hF) begin
         phase_q.push_back('{l1, addr, 1'b1, wdata});
         if (l1 > T) begin e.err = 1'b1; e.lat = T + 1; end
         else begin ref_mem[idx] = wdata; e.lat = l1 + 1; end
      end else if (be != 4'h0) begin
         phase_q.push_back('{l1, addr, 1'b0, 32'd0});
         if (l1 > T) begin
            e.err = 1'b1;
            e.lat = T + 1;
         end else begin
            m = ref_mem[idx];
            for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = wdata[8*i +: 8];
            phase_q.push_back('{l2, addr, 1'b1, m});
            if (l2 > T) begin e.err = 1'b1; e.lat = l1 + T + 2; end
            else begin ref_mem[idx] = m; e.lat = l1 + l2 + 2; end
         end
      end
      if (track) exp_q.push_back(e);
      @(posedge clk);
      #1;
      obi_req   = 1'b0;
      obi_addr  = $urandom;
      obi_we    = 1'($urandom);
      obi_be    = 4'($urandom);
      obi_wdata = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_responses", exp_q.size(), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] w;
      logic [3:0]  b;
      rst       = 1'b1;
      obi_req   = 1'b0;
      obi_addr  = 32'd0;
      obi_we    = 1'b0;
      obi_be    = 4'd0;
      obi_wdata = 32'd0;
      for (int i = 0; i < 16; i++) begin
         w          = $urandom;
         slv_mem[i] = w;
         ref_mem[i] = w;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // Read: ack on cycle 4, response on cycle 5
      slv_mem[1] = 32'hDEADBEEF;
      ref_mem[1] = 32'hDEADBEEF;
      issue(32'h0003_0004, 1'b0, 4'hF, 32'd0, 4, 0, 1'b1);
      // Full write
      issue(BASE + 32'h8, 1'b1, 4'hF, 32'h12345678, 3, 0, 1'b1);
      // Partial write via read-modify-write
      slv_mem[3] = 32'hAABBCCDD;
      ref_mem[3] = 32'hAABBCCDD;
      issue(BASE + 32'hC, 1'b1, 4'b0101, 32'h11223344, 4, 4, 1'b1);
      // Byte-enable zero write: no bus access
      issue(BASE + 32'h10, 1'b1, 4'h0, 32'hCAFEF00D, 1, 1, 1'b1);
      // Timeouts: read, RMW read phase, RMW write phase
      issue(BASE + 32'h14, 1'b0, 4'hF, 32'd0, 20, 0, 1'b1);
      issue(BASE + 32'h18, 1'b1, 4'b0011, 32'h55667788, 20, 3, 1'b1);
      issue(BASE + 32'h1C, 1'b1, 4'b1100, 32'h99AABBCC, 2, 20, 1'b1);
      // Ack on the last allowed cycle wins; one later times out
      issue(BASE + 32'h20, 1'b0, 4'hF, 32'd0, T, 0, 1'b1);
      issue(BASE + 32'h24, 1'b0, 4'hF, 32'd0, T + 1, 0, 1'b1);
      drain();
      chk("rmw_merged_word", slv_mem[3], 32'hAA22CC44);
      chk("full_write_word", slv_mem[2], 32'h12345678);

      // Reset while strobing the RMW read phase: outputs clear, no response
      issue(BASE + 32'h28, 1'b1, 4'b1000, 32'h0BADC0DE, 30, 0, 1'b0);
      @(negedge clk);
      chk("rmw_rd_stb", 32'(wb_stb), 32'd1);
      chk("rmw_rd_we", 32'(wb_we), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_outputs("midreset");
      rst = 1'b0;
      phase_q.delete();
      slv_mem[5] = 32'h13579BDF;
      ref_mem[5] = 32'h13579BDF;
      issue(BASE + 32'h14, 1'b0, 4'hF, 32'd0, 3, 0, 1'b1);
      drain();

      // Randomized traffic with occasional timeouts and idle gaps
      for (int t = 0; t < 300; t++) begin
         case ($urandom_range(0, 3))
            0:       b = 4'hF;
            1:       b = 4'h0;
            default: b = 4'($urandom_range(1, 14));
         endcase
         issue(BASE + {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
               1'($urandom_range(0, 1)), b, $urandom,
               $urandom_range(1, T + 2), $urandom_range(1, T + 2), 1'b1);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      drain();
      chk("phase_queue_empty", phase_q.size(), 32'd0);
      for (int i = 0; i < 16; i++) chk("final_mem", slv_mem[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
